// File: rtl/clock_overlay_writer.sv
// clock_overlay_writer: keeps the running HH:MM:SS time and renders it as
// eight ROM glyphs (HH:MM:SS) into image memory on each start request.
module clock_overlay_writer #(
    parameter int          IMG_W    = 256,
    parameter int          GLYPH_W  = 13,
    parameter int          GLYPH_H  = 24,
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init_load,
    input  logic [23:0]        init_time,
    input  logic               tick_1s,
    input  logic               start,
    input  logic [19:0]        fb_base,
    output logic [8:0]         CR_A,
    input  logic [GLYPH_W-1:0] CR_Q,
    output logic [19:0]        IM_A,
    output logic [23:0]        IM_D,
    output logic               IM_WEN,
    output logic               busy,
    output logic               done,
    output logic [23:0]        cur_time
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;
    localparam logic [3:0] COL_LAST = 4'(GLYPH_W - 1);
    localparam logic [4:0] ROW_LAST = 5'(GLYPH_H - 1);

    logic [7:0]         hh, mm, ss;
    logic               s_wrap, m_wrap;
    logic [2:0]         state;
    logic [2:0]         k;
    logic [4:0]         row;
    logic [3:0]         col;
    logic [23:0]        snap;
    logic [19:0]        base;
    logic [GLYPH_W-1:0] sh;
    logic [7:0]         fld;
    logic [4:0]         glyph;
    logic               wr;

    // >= lets out-of-range loaded fields wrap on the next tick
    assign s_wrap = ss >= 8'd59;
    assign m_wrap = mm >= 8'd59;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {hh, mm, ss} <= '0;
        end else if (init_load) begin
            {hh, mm, ss} <= init_time;
        end else if (tick_1s) begin
            ss <= s_wrap ? 8'd0 : ss + 8'd1;
            if (s_wrap) begin
                mm <= m_wrap ? 8'd0 : mm + 8'd1;
                if (m_wrap)
                    hh <= (hh >= 8'd23) ? 8'd0 : hh + 8'd1;
            end
        end
    end

    assign cur_time = {hh, mm, ss};

    always_comb begin
        fld   = (k < 3'd2) ? snap[23:16] : (k < 3'd5) ? snap[15:8] : snap[7:0];
        glyph = (k == 3'd2 || k == 3'd5) ? 5'd10 :
                (k == 3'd0 || k == 3'd3 || k == 3'd6) ? 5'(fld / 8'd10) : 5'(fld % 8'd10);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            k     <= '0;
            row   <= '0;
            col   <= '0;
            snap  <= '0;
            base  <= '0;
            sh    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= FETCH;
                    k     <= '0;
                    row   <= '0;
                    col   <= '0;
                    snap  <= {hh, mm, ss};
                    base  <= fb_base;
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    sh    <= CR_Q;
                    col   <= '0;
                    state <= WRITE;
                end
                WRITE: if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        row   <= '0;
                        k     <= k + 3'd1;
                        state <= (k == 3'd7) ? FIN : FETCH;
                    end else begin
                        row   <= row + 5'd1;
                        state <= FETCH;
                    end
                end else begin
                    col <= col + 4'd1;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ROM is synchronous: address is presented in FETCH, data captured in LATCH
    assign CR_A   = 9'(32'(glyph) * GLYPH_H + 32'(row));
    assign wr     = state == WRITE;
    assign IM_WEN = !wr;
    assign busy   = state != IDLE;
    assign done   = state == FIN;
    assign IM_A   = wr ? 20'(32'(base) + 32'(row) * IMG_W + 32'(k) * GLYPH_W + 32'(col)) : '0;
    assign IM_D   = wr ? (sh[COL_LAST - col] ? FG_COLOR : BG_COLOR) : '0;
endmodule
